// File: rtl/tribus_arbiter.sv
// Round-robin owner arbiter for a bufif1 tri-state bus with keeper.
// Guarantees a TURN-cycle all-off gap between owners and bounds each tenure to MAX_HOLD cycles.
module tribus_arbiter #(
    parameter int N        = 4,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N-1:0]                         req,
    input  logic [N-1:0]                         done,
    output logic [N-1:0]                         grant,
    output logic [N-1:0]                         oe,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner,
    output logic                                 bus_idle,
    output logic                                 keep_en
);

    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  grant_n;
    logic [OW-1:0] owner_n;
    logic [OW-1:0] ptr, ptr_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [TW-1:0] turn_cnt, turn_n;
    logic          arb;
    logic [OW:0]   pick;

    // Returns {found, index} of the first request after position p, wrapping mod N.
    function automatic logic [OW:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] p);
        logic          found;
        logic [OW-1:0] sel;
        int            idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(p) + k) % N;
            if (!found && r[idx[OW-1:0]]) begin
                found = 1'b1;
                sel   = idx[OW-1:0];
            end
        end
        return {found, sel};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            grant    <= '0;
            owner    <= '0;
            ptr      <= OW'(N - 1);
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            turn_cnt <= turn_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        owner_n = owner;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        turn_n  = turn_cnt;
        arb     = 1'b0;
        pick    = rr_pick(req, ptr);
        case (state)
            S_IDLE: arb = 1'b1;
            S_GRANT: begin
                hold_n = hold_cnt + HW'(1);
                if (done[owner] || !req[owner] || hold_cnt == HOLD_LAST) begin
                    grant_n = '0;
                    turn_n  = TURN_LOAD;
                    state_n = S_TURN;
                end
            end
            S_TURN: begin
                // The final turnaround cycle doubles as an IDLE arbitration cycle.
                if (turn_cnt != '0) begin
                    turn_n = turn_cnt - TW'(1);
                end else begin
                    arb = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (arb) begin
            if (pick[OW]) begin
                grant_n                = '0;
                grant_n[pick[OW-1:0]] = 1'b1;
                owner_n                = pick[OW-1:0];
                ptr_n                  = pick[OW-1:0];
                hold_n                 = '0;
                state_n                = S_GRANT;
            end else begin
                state_n = S_IDLE;
            end
        end
    end

    // Enables come straight from registers so no driver ever sees a req-driven glitch.
    assign oe       = grant;
    assign bus_idle = (state != S_GRANT);
    assign keep_en  = bus_idle;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Bench for tribus_arbiter: two configurations share stimulus; a reference model feeds a scoreboard.
module tb_tribus_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] done = '0;

    logic [3:0] grant_a, oe_a, grant_b, oe_b;
    logic [1:0] owner_a, owner_b;
    logic       idle_a, keep_a, idle_b, keep_b;

    always #5 clk = ~clk;

    tribus_arbiter #(.N(4), .TURN(1), .MAX_HOLD(8)) dut_a (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant_a), .oe(oe_a), .owner(owner_a), .bus_idle(idle_a), .keep_en(keep_a)
    );

    tribus_arbiter #(.N(4), .TURN(3), .MAX_HOLD(4)) dut_b (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant_b), .oe(oe_b), .owner(owner_b), .bus_idle(idle_b), .keep_en(keep_b)
    );

    typedef struct packed {
        logic [3:0] ga;
        logic [1:0] oa;
        logic [3:0] gb;
        logic [1:0] ob;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    int m_own[2];
    int m_ptr[2];
    int m_held[2];
    int m_gap[2];

    logic [3:0] prev_a = '0, prev_b = '0;
    logic [3:0] obs_a = '0, obs_b = '0;
    int run_a = 0, run_b = 0;
    int wait_a[4], wait_b[4];
    int max_wait_a = 0, max_wait_b = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    function automatic int turn_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int mh_of(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic logic [3:0] onehot(input int o);
        return (o < 0) ? 4'b0000 : (4'b0001 << o);
    endfunction

    // Model: bus is free for m_gap completed cycles; a new owner may be picked once TURN free cycles have elapsed.
    task automatic model_step(input int k);
        int  g;
        int  s0;
        bit  found;
        if (rst) begin
            m_own[k]  = -1;
            m_ptr[k]  = N - 1;
            m_held[k] = 0;
            m_gap[k]  = turn_of(k);
        end else if (m_own[k] >= 0) begin
            if (done[2'(m_own[k])] || !req[2'(m_own[k])] || m_held[k] >= mh_of(k)) begin
                m_own[k] = -1;
                m_gap[k] = 0;
            end else begin
                m_held[k]++;
            end
        end else begin
            g = m_gap[k] + 1;
            if (g > turn_of(k)) g = turn_of(k);
            m_gap[k] = g;
            if (g >= turn_of(k) && req != 4'b0000) begin
                s0    = m_ptr[k];
                found = 1'b0;
                for (int j = 1; j <= N; j++) begin
                    if (!found && req[2'((s0 + j) % N)]) begin
                        found     = 1'b1;
                        m_own[k]  = (s0 + j) % N;
                    end
                end
                m_ptr[k]  = m_own[k];
                m_held[k] = 1;
                m_gap[k]  = 0;
            end
        end
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("grant_a", 32'(grant_a), 32'(e.ga));
        chk("oe_a", 32'(oe_a), 32'(e.ga));
        chk("idle_a", 32'(idle_a), 32'(e.ga == 4'b0000));
        chk("keep_a", 32'(keep_a), 32'(e.ga == 4'b0000));
        if (e.ga != 4'b0000) chk("owner_a", 32'(owner_a), 32'(e.oa));
        chk("grant_b", 32'(grant_b), 32'(e.gb));
        chk("oe_b", 32'(oe_b), 32'(e.gb));
        chk("idle_b", 32'(idle_b), 32'(e.gb == 4'b0000));
        chk("keep_b", 32'(keep_b), 32'(e.gb == 4'b0000));
        if (e.gb != 4'b0000) chk("owner_b", 32'(owner_b), 32'(e.ob));
        chk("onehot_a", 32'($onehot0(oe_a)), 32'd1);
        chk("onehot_b", 32'($onehot0(oe_b)), 32'd1);
        chk("keepinv_a", 32'(keep_a), 32'(oe_a == 4'b0000));
        chk("keepinv_b", 32'(keep_b), 32'(oe_b == 4'b0000));
        chk("nohop_a", 32'(prev_a != 0 && oe_a != 0 && prev_a != oe_a), 32'd0);
        chk("nohop_b", 32'(prev_b != 0 && oe_b != 0 && prev_b != oe_b), 32'd0);
        run_a = (grant_a == 4'b0000) ? 0 : ((grant_a == prev_a) ? run_a + 1 : 1);
        run_b = (grant_b == 4'b0000) ? 0 : ((grant_b == prev_b) ? run_b + 1 : 1);
        chk("hold_a", 32'(run_a <= 8), 32'd1);
        chk("hold_b", 32'(run_b <= 4), 32'd1);
        prev_a = oe_a;
        prev_b = oe_b;
        obs_a  = grant_a;
        obs_b  = grant_b;
    endtask

    // One clock: check what the last edge produced, drive this cycle's inputs, queue the model's prediction.
    task automatic step(input logic [3:0] r, input logic [3:0] d, input logic rs);
        exp_t e;
        @(negedge clk);
        compare();
        req  = r;
        done = d;
        rst  = rs;
        model_step(0);
        model_step(1);
        e.ga = onehot(m_own[0]);
        e.oa = 2'(m_own[0]);
        e.gb = onehot(m_own[1]);
        e.ob = 2'(m_own[1]);
        sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            if (!rs && req[i] && !grant_a[i]) wait_a[i]++; else wait_a[i] = 0;
            if (!rs && req[i] && !grant_b[i]) wait_b[i]++; else wait_b[i] = 0;
            if (wait_a[i] > max_wait_a) max_wait_a = wait_a[i];
            if (wait_b[i] > max_wait_b) max_wait_b = wait_b[i];
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq[13];
        logic [3:0] ea[12];
        logic [3:0] eb[12];
        logic [3:0] r, d;
        seq = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1};
        ea  = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4};
        eb  = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
        for (int i = 0; i < 4; i++) begin
            wait_a[i] = 0;
            wait_b[i] = 0;
        end

        // Reset held two cycles with all requesting, then round-robin with done in the 2nd grant cycle
        step(4'hf, 4'h0, 1'b1);
        step(4'hf, 4'h0, 1'b1);
        step(4'hf, 4'h0, 1'b0);
        chk("rst_grant", 32'(obs_a), 32'h0);
        chk("rst_idle", 32'(idle_a & keep_a), 32'd1);
        for (int i = 0; i < 13; i++) begin
            d = (m_own[0] >= 0 && m_held[0] == 2) ? onehot(m_own[0]) : 4'h0;
            step(4'hf, d, 1'b0);
            chk("rr_seq", 32'(obs_a), 32'(seq[i]));
        end

        // Single requester released by done after four cycles
        step(4'h0, 4'h0, 1'b1);
        step(4'h1, 4'h0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            step(4'h1, (c == 4) ? 4'h1 : 4'h0, 1'b0);
            chk("done_grant", 32'(obs_a), 32'h1);
        end
        step(4'h0, 4'h0, 1'b0);
        chk("done_free", 32'(obs_a), 32'h0);
        chk("done_idle", 32'(idle_a), 32'd1);

        // Hold limit with a lone requester: re-granted after exactly TURN idle cycles
        step(4'h0, 4'h0, 1'b1);
        step(4'h4, 4'h0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(4'h4, 4'h0, 1'b0);
            chk("maxhold_a", 32'(obs_a), 32'(ea[i]));
            chk("maxhold_b", 32'(obs_b), 32'(eb[i]));
        end

        // Reset mid-grant restores the pointer
        step(4'h0, 4'h0, 1'b1);
        step(4'ha, 4'h0, 1'b0);
        step(4'ha, 4'h2, 1'b0);
        chk("mid_first", 32'(obs_a), 32'h2);
        step(4'ha, 4'h0, 1'b0);
        step(4'ha, 4'h0, 1'b1);
        chk("mid_owner3", 32'(obs_a), 32'h8);
        step(4'ha, 4'h0, 1'b0);
        chk("mid_rst", 32'(obs_a), 32'h0);
        step(4'ha, 4'h0, 1'b0);
        chk("mid_after", 32'(obs_a), 32'h2);

        // Random traffic; done pulses hit owners and non-owners alike
        step(4'h0, 4'h0, 1'b1);
        r = 4'h0;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!r[i]) r[i] = ($urandom_range(0, 99) < 30);
                else if ((m_own[0] == i || m_own[1] == i) && $urandom_range(0, 99) < 25) r[i] = 1'b0;
                d[i] = ($urandom_range(0, 99) < 15);
            end
            step(r, d, 1'b0);
        end
        step(4'h0, 4'h0, 1'b0);
        chk("starve_a", 32'(max_wait_a <= 4 * (8 + 1) + 1), 32'd1);
        chk("starve_b", 32'(max_wait_b <= 4 * (4 + 3) + 1), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
